// File: rtl/uart_pkg.sv
// Shared UART transmit definitions: baud-select encodings, rate table,
// bit-period arithmetic and frame geometry.
package uart_pkg;

  localparam int FRAME_LEN = 10;

  typedef enum logic [2:0] {
    BAUD_9600   = 3'd0,
    BAUD_19200  = 3'd1,
    BAUD_38400  = 3'd2,
    BAUD_57600  = 3'd3,
    BAUD_115200 = 3'd4
  } baud_sel_e;

  localparam int BAUD_RATE [5] = '{9600, 19200, 38400, 57600, 115200};

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } tx_state_e;

  function automatic int calc_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  // The slowest rate has the longest period, so it sets the counter width.
  function automatic int div_width(input int clk_freq);
    return $clog2(calc_div(clk_freq, BAUD_RATE[0]));
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period divider: counts clocks while enabled and emits a one-cycle tick
// on the last clock of each bit period selected by the latched baud code.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_en,
  input  logic [2:0] i_baud_set,
  output logic       o_bit_tick
);

  localparam int CNT_W = div_width(CLK_FREQ);

  localparam logic [CNT_W-1:0] DIV_M1_0 = CNT_W'(calc_div(CLK_FREQ, BAUD_RATE[0]) - 1);
  localparam logic [CNT_W-1:0] DIV_M1_1 = CNT_W'(calc_div(CLK_FREQ, BAUD_RATE[1]) - 1);
  localparam logic [CNT_W-1:0] DIV_M1_2 = CNT_W'(calc_div(CLK_FREQ, BAUD_RATE[2]) - 1);
  localparam logic [CNT_W-1:0] DIV_M1_3 = CNT_W'(calc_div(CLK_FREQ, BAUD_RATE[3]) - 1);
  localparam logic [CNT_W-1:0] DIV_M1_4 = CNT_W'(calc_div(CLK_FREQ, BAUD_RATE[4]) - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_div_m1;

  // Unused codes fall back to the slowest rate.
  always_comb begin
    w_div_m1 = DIV_M1_0;
    case (i_baud_set)
      BAUD_19200:  w_div_m1 = DIV_M1_1;
      BAUD_38400:  w_div_m1 = DIV_M1_2;
      BAUD_57600:  w_div_m1 = DIV_M1_3;
      BAUD_115200: w_div_m1 = DIV_M1_4;
      default:     w_div_m1 = DIV_M1_0;
    endcase
  end

  assign o_bit_tick = i_en && (r_cnt == w_div_m1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!i_en || o_bit_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_byte_tx.sv
// Single-byte UART transmitter: 8N1 framing, idle-high line, selectable baud,
// one-cycle done pulse; requests arriving mid-frame are dropped.
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_byte,
  input  logic       send_en,
  input  logic [2:0] baud_set,
  output logic       uart_tx,
  output logic       tx_done,
  output logic       uart_state
);

  localparam logic [3:0] LAST_BIT = 4'(FRAME_LEN - 1);
  localparam logic [3:0] STOP_BIT = 4'(FRAME_LEN - 2);

  tx_state_e  r_state;
  logic [7:0] r_data;
  logic [2:0] r_baud;
  logic [3:0] r_bit_idx;
  logic       w_bit_tick;

  uart_baud_gen #(
    .CLK_FREQ (CLK_FREQ)
  ) u_baud_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_en       (r_state == ST_BUSY),
    .i_baud_set (r_baud),
    .o_bit_tick (w_bit_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_data     <= '0;
      r_baud     <= '0;
      r_bit_idx  <= '0;
      uart_tx    <= 1'b1;
      tx_done    <= 1'b0;
      uart_state <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          uart_tx <= 1'b1;
          if (send_en) begin
            r_state    <= ST_BUSY;
            r_data     <= data_byte;
            r_baud     <= baud_set;
            r_bit_idx  <= '0;
            uart_state <= 1'b1;
            uart_tx    <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (w_bit_tick) begin
            if (r_bit_idx == LAST_BIT) begin
              r_state    <= ST_IDLE;
              r_bit_idx  <= '0;
              uart_state <= 1'b0;
              tx_done    <= 1'b1;
              uart_tx    <= 1'b1;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
              // Drive the bit that the index is about to point at.
              if (r_bit_idx == STOP_BIT) begin
                uart_tx <= 1'b1;
              end else begin
                uart_tx <= r_data[r_bit_idx[2:0]];
              end
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_byte_tx.sv
// Directed bench for uart_byte_tx at 50 MHz: framing, timing, busy-ignore,
// back-to-back frames, mid-frame reset and mid-frame baud changes.
module tb_uart_byte_tx;

  logic       clk;
  logic       rst_n;
  logic [7:0] data_byte;
  logic       send_en;
  logic [2:0] baud_set;
  logic       uart_tx;
  logic       tx_done;
  logic       uart_state;

  int checks;
  int errors;

  uart_byte_tx #(
    .CLK_FREQ (50_000_000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_byte  (data_byte),
    .send_en    (send_en),
    .baud_set   (baud_set),
    .uart_tx    (uart_tx),
    .tx_done    (tx_done),
    .uart_state (uart_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a falling edge; the request is taken on the next rising edge.
  task automatic pulse_send(input logic [7:0] d, input logic [2:0] b);
    data_byte = d;
    baud_set  = b;
    send_en   = 1'b1;
    @(posedge clk);
    #1 send_en = 1'b0;
  endtask

  // Samples one frame on falling edges starting the cycle after acceptance.
  // Records each bit's first value, counts in-bit changes, busy cycles and
  // early done pulses; optionally injects a request/input change at inj_c.
  task automatic watch_frame(input int div, input int ncyc, input int inj_c,
                             input logic [7:0] inj_data, input logic [2:0] inj_baud,
                             output logic [9:0] bits, output int glitch,
                             output int state_cyc, output int early_done,
                             output logic done_seen, output logic st_at_done,
                             output logic tx_at_done);
    int total;
    int last;
    total = 10 * div;
    last = (ncyc < total) ? ncyc : total;
    bits = '0;
    glitch = 0;
    state_cyc = 0;
    early_done = 0;
    done_seen = 1'b0;
    st_at_done = 1'b1;
    tx_at_done = 1'b0;
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      if (c < total) begin
        if (c % div == 0) bits[c / div] = uart_tx;
        else if (uart_tx !== bits[c / div]) glitch++;
        if (uart_state === 1'b1) state_cyc++;
        if (tx_done !== 1'b0) early_done++;
      end else begin
        done_seen  = tx_done;
        st_at_done = uart_state;
        tx_at_done = uart_tx;
      end
      if (c == inj_c) begin
        data_byte = inj_data;
        baud_set  = inj_baud;
        send_en   = 1'b1;
      end else if (c == inj_c + 1) begin
        send_en = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if (uart_tx !== 1'b1) begin
      errors++;
      $display("FAIL reset_uart_tx got %b want 1", uart_tx);
    end
    checks++;
    if (tx_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_tx_done got %b want 0", tx_done);
    end
    checks++;
    if (uart_state !== 1'b0) begin
      errors++;
      $display("FAIL reset_uart_state got %b want 0", uart_state);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_baud115200_a5;
    logic [9:0] bits;
    int g, sc, ed;
    logic dn, sd, td;
    pulse_send(8'hA5, 3'd4);
    watch_frame(434, 4340, -1, 8'h00, 3'd0, bits, g, sc, ed, dn, sd, td);
    checks++;
    if (bits !== 10'h34A) begin
      errors++;
      $display("FAIL a5_bits got %h want 34a", bits);
    end
    checks++;
    if (g !== 0) begin
      errors++;
      $display("FAIL a5_bit_hold got %0d changes want 0", g);
    end
    checks++;
    if (sc !== 4340) begin
      errors++;
      $display("FAIL a5_busy_cycles got %0d want 4340", sc);
    end
    checks++;
    if (ed !== 0 || dn !== 1'b1 || sd !== 1'b0 || td !== 1'b1) begin
      errors++;
      $display("FAIL a5_done early=%0d done=%b state=%b tx=%b want 0 1 0 1", ed, dn, sd, td);
    end
    @(negedge clk);
    checks++;
    if (tx_done !== 1'b0 || uart_state !== 1'b0 || uart_tx !== 1'b1) begin
      errors++;
      $display("FAIL a5_after_done done=%b state=%b tx=%b want 0 0 1", tx_done, uart_state, uart_tx);
    end
  endtask

  task automatic test_baud9600_zero;
    logic [9:0] bits;
    int g, sc, ed;
    logic dn, sd, td;
    pulse_send(8'h00, 3'd0);
    watch_frame(5208, 52080, -1, 8'h00, 3'd0, bits, g, sc, ed, dn, sd, td);
    checks++;
    if (bits !== 10'h200 || g !== 0) begin
      errors++;
      $display("FAIL zero_bits got %h changes %0d want 200 0", bits, g);
    end
    checks++;
    if (sc !== 52080 || sd !== 1'b0) begin
      errors++;
      $display("FAIL zero_busy_cycles got %0d end_state %b want 52080 0", sc, sd);
    end
    checks++;
    if (ed !== 0 || dn !== 1'b1) begin
      errors++;
      $display("FAIL zero_done early=%0d done=%b want 0 1", ed, dn);
    end
  endtask

  task automatic test_busy_ignore;
    logic [9:0] bits;
    int g, sc, ed, late;
    logic dn, sd, td;
    pulse_send(8'hA5, 3'd4);
    watch_frame(434, 4340, 3 * 434 + 50, 8'h96, 3'd4, bits, g, sc, ed, dn, sd, td);
    checks++;
    if (bits !== 10'h34A || g !== 0) begin
      errors++;
      $display("FAIL ignore_bits got %h changes %0d want 34a 0", bits, g);
    end
    checks++;
    if (ed !== 0 || dn !== 1'b1) begin
      errors++;
      $display("FAIL ignore_done early=%0d done=%b want 0 1", ed, dn);
    end
    late = 0;
    repeat (20) begin
      @(negedge clk);
      if (uart_state !== 1'b0 || uart_tx !== 1'b1 || tx_done !== 1'b0) late++;
    end
    checks++;
    if (late !== 0) begin
      errors++;
      $display("FAIL ignore_no_restart got %0d active cycles want 0", late);
    end
  endtask

  task automatic test_back_to_back;
    logic [9:0] bits;
    int g, sc, ed;
    logic dn, sd, td;
    pulse_send(8'h81, 3'd4);
    watch_frame(434, 4340, -1, 8'h00, 3'd0, bits, g, sc, ed, dn, sd, td);
    checks++;
    if (bits !== 10'h302 || dn !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first got %h done %b want 302 1", bits, dn);
    end
    pulse_send(8'h3C, 3'd4);
    watch_frame(434, 4340, -1, 8'h00, 3'd0, bits, g, sc, ed, dn, sd, td);
    checks++;
    if (bits !== 10'h278 || g !== 0 || sc !== 4340) begin
      errors++;
      $display("FAIL b2b_second got %h changes %0d busy %0d want 278 0 4340", bits, g, sc);
    end
    checks++;
    if (ed !== 0 || dn !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second_done early=%0d done=%b want 0 1", ed, dn);
    end
    @(negedge clk);
    checks++;
    if (tx_done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done_width got %b want 0", tx_done);
    end
  endtask

  task automatic test_reset_midframe;
    logic [9:0] bits;
    int g, sc, ed, bad;
    logic dn, sd, td;
    pulse_send(8'hA5, 3'd4);
    repeat (5 * 434 + 200) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (uart_tx !== 1'b1 || uart_state !== 1'b0) begin
      errors++;
      $display("FAIL abort_immediate tx=%b state=%b want 1 0", uart_tx, uart_state);
    end
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (tx_done !== 1'b0 || uart_tx !== 1'b1) bad++;
    end
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (tx_done !== 1'b0 || uart_tx !== 1'b1 || uart_state !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL abort_quiet got %0d bad cycles want 0", bad);
    end
    pulse_send(8'h5A, 3'd4);
    watch_frame(434, 4340, -1, 8'h00, 3'd0, bits, g, sc, ed, dn, sd, td);
    checks++;
    if (bits !== 10'h2B4 || g !== 0 || dn !== 1'b1) begin
      errors++;
      $display("FAIL abort_next_frame got %h changes %0d done %b want 2b4 0 1", bits, g, dn);
    end
  endtask

  task automatic test_baud_default_and_change;
    logic [9:0] bits;
    int g, sc, ed;
    logic dn, sd, td;
    pulse_send(8'h55, 3'd7);
    watch_frame(5208, 2 * 5208, 100, 8'h55, 3'd4, bits, g, sc, ed, dn, sd, td);
    checks++;
    if (bits[2:0] !== 3'b010 || g !== 0) begin
      errors++;
      $display("FAIL baud7_bits got %b changes %0d want 010 0", bits[2:0], g);
    end
    checks++;
    if (sc !== 10417 || ed !== 0) begin
      errors++;
      $display("FAIL baud7_busy got %0d early_done %0d want 10417 0", sc, ed);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (uart_tx !== 1'b1) begin
      errors++;
      $display("FAIL baud7_abort tx got %b want 1", uart_tx);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    send_en   = 1'b0;
    data_byte = 8'h00;
    baud_set  = 3'd0;
    test_reset();
    test_baud115200_a5();
    test_baud9600_zero();
    test_busy_ignore();
    test_back_to_back();
    test_reset_midframe();
    test_baud_default_and_change();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
